// File: rtl/mips_pkg.sv
// Shared ALU control encodings for the multicycle MIPS datapath (alu and aludec).
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Result selector carried in alucontrol[1:0].
    typedef enum logic [1:0] {
        SEL_AND = 2'b00,
        SEL_OR  = 2'b01,
        SEL_SUM = 2'b10,
        SEL_SLT = 2'b11
    } alu_sel_e;

    // alucontrol[2] inverts B and doubles as the adder carry-in.
    function automatic logic alu_inverts_b(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/mips_alu_flops_adder32.sv
// 32-bit wrap-around adder with carry-in, used by the ALU for add/sub/slt.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s
);

    assign s = a + b + {31'b0, cin};

endmodule

// File: rtl/mips_alu_flops.sv
// ALU and register primitives of the multicycle MIPS datapath, plus a wrapper
// that exposes one of each for standalone use.
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  f,
    output logic [31:0] y,
    output logic        zero
);

    logic [31:0] bb;
    logic [31:0] s;
    logic        inv;
    alu_sel_e    sel;

    assign inv = alu_inverts_b(f);
    assign bb  = inv ? ~b : b;
    assign sel = alu_sel_e'(f[1:0]);

    adder32 u_adder (
        .a   (a),
        .b   (bb),
        .cin (inv),
        .s   (s)
    );

    // SLT reports only the sign of a-b; signed overflow is deliberately ignored.
    always_comb begin
        y = '0;
        case (sel)
            SEL_AND: y = a & bb;
            SEL_OR:  y = a | bb;
            SEL_SUM: y = s;
            SEL_SLT: y = {31'b0, s[31]};
            default: y = '0;
        endcase
    end

    assign zero = ~|y;

endmodule

module flopr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

module flopenr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

module mips_alu_flops #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [2:0]       f,
    output logic [31:0]      y,
    output logic             zero,
    input  logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] rq,
    input  logic             en,
    input  logic [WIDTH-1:0] ed,
    output logic [WIDTH-1:0] eq
);

    alu u_alu (
        .a    (a),
        .b    (b),
        .f    (f),
        .y    (y),
        .zero (zero)
    );

    flopr #(.WIDTH(WIDTH)) u_flopr (
        .clk   (clk),
        .reset (reset),
        .d     (rd),
        .q     (rq)
    );

    flopenr #(.WIDTH(WIDTH)) u_flopenr (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (ed),
        .q     (eq)
    );

endmodule

// File: tb/tb_mips_alu_flops.sv
// Scoreboard bench for the MIPS ALU and the flopr/flopenr registers at WIDTH=32.
module tb_mips_alu_flops;

    localparam int unsigned W = 32;

    logic          clk;
    logic          reset;
    logic [31:0]   a, b, y;
    logic [2:0]    f;
    logic          zero;
    logic [W-1:0]  rd, rq, ed, eq;
    logic          en;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] y;
        logic        zero;
    } alu_exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
        logic        zero;
    } vec_t;

    alu_exp_t     alu_q[$];
    logic [W-1:0] reg_q[$];

    mips_alu_flops #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .f     (f),
        .y     (y),
        .zero  (zero),
        .rd    (rd),
        .rq    (rq),
        .en    (en),
        .ed    (ed),
        .eq    (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU written from the opcode table, not from the invert/carry datapath.
    function automatic alu_exp_t alu_model(input logic [31:0] ma, input logic [31:0] mb,
                                           input logic [2:0] mf);
        alu_exp_t    r;
        logic [31:0] sum, dif;
        sum = ma + mb;
        dif = ma - mb;
        case (mf)
            3'b000:  r.y = ma & mb;
            3'b001:  r.y = ma | mb;
            3'b010:  r.y = sum;
            3'b011:  r.y = {31'b0, sum[31]};
            3'b100:  r.y = ma & ~mb;
            3'b101:  r.y = ma | ~mb;
            3'b110:  r.y = dif;
            default: r.y = {31'b0, dif[31]};
        endcase
        r.zero = (r.y == 32'd0);
        return r;
    endfunction

    task automatic test_reset();
        alu_exp_t dummy;
        reset = 1'b1;
        en = 1'b0; rd = '0; ed = '0; a = '0; b = '0; f = 3'b000;
        #1;
        checks++;
        if (rq !== '0) begin errors++; $display("FAIL reset_rq got %h want %h", rq, 32'h0); end
        checks++;
        if (eq !== '0) begin errors++; $display("FAIL reset_eq got %h want %h", eq, 32'h0); end
        dummy = alu_model(32'd0, 32'd0, 3'b000);
        checks++;
        if (zero !== dummy.zero) begin errors++; $display("FAIL reset_alu_zero got %b want %b", zero, dummy.zero); end
    endtask

    task automatic test_alu_table();
        vec_t     tbl[13];
        alu_exp_t e;
        tbl = '{
            '{32'd5,        32'd7,        3'b010, 32'd12,       1'b0},
            '{32'd7,        32'd7,        3'b110, 32'd0,        1'b1},
            '{32'd0,        32'd1,        3'b110, 32'hFFFFFFFF, 1'b0},
            '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0},
            '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0, 1'b0},
            '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 32'hF000F000, 1'b0},
            '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b101, 32'hF0FFF0FF, 1'b0},
            '{32'hFFFFFFFD, 32'd2,        3'b111, 32'd1,        1'b0},
            '{32'd2,        32'hFFFFFFFD, 3'b111, 32'd0,        1'b1},
            '{32'd4,        32'd4,        3'b111, 32'd0,        1'b1},
            '{32'h80000000, 32'd1,        3'b111, 32'd0,        1'b1},
            '{32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b1},
            '{32'h7FFFFFFF, 32'd1,        3'b011, 32'd1,        1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            a = tbl[i].a; b = tbl[i].b; f = tbl[i].f;
            alu_q.push_back('{tbl[i].y, tbl[i].zero});
            #1;
            e = alu_q.pop_front();
            checks++;
            if (y !== e.y || zero !== e.zero) begin
                errors++;
                $display("FAIL alu_table[%0d] f=%b got y=%h zero=%b want y=%h zero=%b",
                         i, f, y, zero, e.y, e.zero);
            end
        end
    endtask

    task automatic test_alu_random();
        alu_exp_t e;
        for (int i = 0; i < 64; i++) begin
            a = $urandom();
            b = (i % 4 == 0) ? a : $urandom();
            f = 3'(i % 8);
            alu_q.push_back(alu_model(a, b, f));
            #1;
            e = alu_q.pop_front();
            checks++;
            if (y !== e.y || zero !== e.zero) begin
                errors++;
                $display("FAIL alu_rand[%0d] a=%h b=%h f=%b got y=%h zero=%b want y=%h zero=%b",
                         i, a, b, f, y, zero, e.y, e.zero);
            end
        end
    endtask

    task automatic test_flopr();
        logic [W-1:0] e;
        @(negedge clk);
        reset = 1'b0;
        rd = 32'hDEADBEEF;
        reg_q.push_back(32'hDEADBEEF);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            e = reg_q.pop_front();
            checks++;
            if (rq !== e) begin errors++; $display("FAIL flopr_capture[%0d] got %h want %h", i, rq, e); end
            @(negedge clk);
            rd = $urandom();
            reg_q.push_back(rd);
        end
        @(posedge clk); #1;
        e = reg_q.pop_front();
        checks++;
        if (rq !== e) begin errors++; $display("FAIL flopr_b2b_last got %h want %h", rq, e); end
        // d changing between edges must not reach q
        #1 rd = ~e;
        #1;
        checks++;
        if (rq !== e) begin errors++; $display("FAIL flopr_hold_between_edges got %h want %h", rq, e); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (rq !== '0) begin errors++; $display("FAIL flopr_async_reset got %h want %h", rq, 32'h0); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_flopenr();
        logic [W-1:0] e;
        @(negedge clk);
        en = 1'b0;
        ed = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (eq !== '0) begin errors++; $display("FAIL flopenr_disabled[%0d] got %h want %h", i, eq, 32'h0); end
        end
        @(negedge clk);
        en = 1'b1;
        reg_q.push_back(32'h12345678);
        @(posedge clk); #1;
        e = reg_q.pop_front();
        checks++;
        if (eq !== e) begin errors++; $display("FAIL flopenr_load got %h want %h", eq, e); end
        @(negedge clk);
        en = 1'b0;
        ed = 32'hCAFEF00D;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (eq !== e) begin errors++; $display("FAIL flopenr_hold[%0d] got %h want %h", i, eq, e); end
        end
        // pending enable, then reset mid-cycle and held across an edge
        @(negedge clk);
        en = 1'b1;
        ed = 32'h55AA55AA;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (eq !== '0) begin errors++; $display("FAIL flopenr_async_reset got %h want %h", eq, 32'h0); end
        @(posedge clk); #1;
        checks++;
        if (eq !== '0) begin errors++; $display("FAIL flopenr_reset_dominates got %h want %h", eq, 32'h0); end
        @(negedge clk);
        reset = 1'b0;
        ed = 32'h0BADCAFE;
        reg_q.push_back(32'h0BADCAFE);
        @(posedge clk); #1;
        e = reg_q.pop_front();
        checks++;
        if (eq !== e) begin errors++; $display("FAIL flopenr_first_after_reset got %h want %h", eq, e); end
    endtask

    initial begin
        test_reset();
        test_alu_table();
        test_alu_random();
        test_flopr();
        test_flopenr();
        checks++;
        if (alu_q.size() != 0 || reg_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d want 0/0", alu_q.size(), reg_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
